// File: rtl/dram_pkg.sv
// Shared types, address field positions and timing defaults for the DRAM command scheduler.
package dram_pkg;

  localparam int unsigned AddrW     = 33;
  localparam int unsigned RowW      = 15;
  localparam int unsigned ColW      = 8;
  localparam int unsigned NumBanks  = 16;
  localparam int unsigned BankIdxW  = 4;
  localparam int unsigned CntW      = 8;

  // Byte-address field positions.
  localparam int unsigned BgLsb  = 6;
  localparam int unsigned BaLsb  = 8;
  localparam int unsigned ColLsb = 10;
  localparam int unsigned RowLsb = 18;

  // Timing defaults in clocks.
  localparam int unsigned TRcdDef   = 24;
  localparam int unsigned TRpDef    = 24;
  localparam int unsigned TClDef    = 24;
  localparam int unsigned TCwlDef   = 20;
  localparam int unsigned TBurstDef = 4;

  typedef enum logic [2:0] {
    CmdNop = 3'd0,
    CmdAct = 3'd1,
    CmdPre = 3'd2,
    CmdRd  = 3'd3,
    CmdWr  = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    OpRead  = 2'd0,
    OpWrite = 2'd1,
    OpFetch = 2'd2,
    OpRsvd  = 2'd3
  } op_e;

  function automatic logic [1:0] addr_bg(input logic [AddrW-1:0] addr);
    return addr[BgLsb +: 2];
  endfunction

  function automatic logic [1:0] addr_ba(input logic [AddrW-1:0] addr);
    return addr[BaLsb +: 2];
  endfunction

  function automatic logic [RowW-1:0] addr_row(input logic [AddrW-1:0] addr);
    return addr[RowLsb +: RowW];
  endfunction

  function automatic logic [ColW-1:0] addr_col(input logic [AddrW-1:0] addr);
    return addr[ColLsb +: ColW];
  endfunction

  // Bank table index is {BG, BA}.
  function automatic logic [BankIdxW-1:0] addr_bank(input logic [AddrW-1:0] addr);
    return {addr_bg(addr), addr_ba(addr)};
  endfunction

  // Only op 1 writes; fetch and reserved ops behave as reads.
  function automatic cmd_e cas_cmd(input logic [1:0] op);
    return (op == OpWrite) ? CmdWr : CmdRd;
  endfunction

endpackage

// File: rtl/dram_cmd_sched_if.sv
// Request / command / response bundle between a requester and the DRAM command scheduler.
interface dram_cmd_sched_if;
  import dram_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [AddrW-1:0]    req_addr;

  logic                cmd_valid;
  logic [2:0]          cmd_type;
  logic [1:0]          cmd_bg;
  logic [1:0]          cmd_ba;
  logic [RowW-1:0]     cmd_row;
  logic [ColW-1:0]     cmd_col;

  logic                rsp_valid;
  logic [1:0]          rsp_op;
  logic [AddrW-1:0]    rsp_addr;

  logic                busy;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col,
    input  rsp_valid, rsp_op, rsp_addr, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col,
    output rsp_valid, rsp_op, rsp_addr, busy
  );

endinterface

// File: rtl/dram_bank_table.sv
// Per-bank open-page state: an open bit and the open row for each {BG, BA}.
module dram_bank_table
  import dram_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BankIdxW-1:0] lkp_idx,
  output logic                lkp_open,
  output logic [RowW-1:0]     lkp_row,
  input  logic                upd_en,
  input  logic [BankIdxW-1:0] upd_idx,
  input  logic                upd_open,
  input  logic [RowW-1:0]     upd_row
);

  logic [NumBanks-1:0] open_q;
  logic [RowW-1:0]     row_q [NumBanks];

  // Entries change only when a PRE or ACT is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int i = 0; i < NumBanks; i++) begin
        row_q[i] <= '0;
      end
    end else if (upd_en) begin
      open_q[upd_idx] <= upd_open;
      row_q[upd_idx]  <= upd_row;
    end
  end

  assign lkp_open = open_q[lkp_idx];
  assign lkp_row  = row_q[lkp_idx];

endmodule

// File: rtl/dram_cmd_sched.sv
// Single-request DRAM command scheduler: classifies each request against the bank table and
// issues PRE/ACT/RD/WR with fixed timing, then pulses a completion once the data burst ends.
module dram_cmd_sched
  import dram_pkg::*;
#(
  parameter int unsigned T_RCD   = TRcdDef,
  parameter int unsigned T_RP    = TRpDef,
  parameter int unsigned T_CL    = TClDef,
  parameter int unsigned T_CWL   = TCwlDef,
  parameter int unsigned T_BURST = TBurstDef
) (
  input logic             clk,
  input logic             rst_n,
  dram_cmd_sched_if.slave bus
);

  if (T_RCD == 0 || T_RCD > 255 || T_RP == 0 || T_RP > 255 || T_CL == 0 || T_CL > 255 ||
      T_CWL == 0 || T_CWL > 255 || T_BURST == 0 || T_BURST > 255) begin : g_bad_timing
    $error("dram_cmd_sched: timing parameters must be 1..255");
  end

  localparam logic [CntW-1:0] TRcd   = CntW'(T_RCD);
  localparam logic [CntW-1:0] TRp    = CntW'(T_RP);
  localparam logic [CntW-1:0] TCl    = CntW'(T_CL);
  localparam logic [CntW-1:0] TCwl   = CntW'(T_CWL);
  localparam logic [CntW-1:0] TBurst = CntW'(T_BURST);

  // Each state names the command already on the bus (or the wait that follows it).
  typedef enum logic [2:0] {StIdle, StPre, StAct, StCas, StData} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              burst_q, burst_d;
  logic [1:0]        op_q, op_d;
  logic [AddrW-1:0]  addr_q, addr_d;

  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              cmd_valid_q, cmd_valid_d;
  cmd_e              cmd_type_q, cmd_type_d;
  logic [1:0]        cmd_bg_q, cmd_bg_d;
  logic [1:0]        cmd_ba_q, cmd_ba_d;
  logic [RowW-1:0]   cmd_row_q, cmd_row_d;
  logic [ColW-1:0]   cmd_col_q, cmd_col_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_op_q, rsp_op_d;
  logic [AddrW-1:0]  rsp_addr_q, rsp_addr_d;

  logic              accept;
  logic [AddrW-1:0]  src_addr;
  logic [1:0]        src_op;
  logic [CntW-1:0]   lat;
  logic              issue_pre, issue_act, issue_cas;

  logic                lkp_open;
  logic [RowW-1:0]     lkp_row;
  logic                upd_en, upd_open;
  logic [RowW-1:0]     upd_row;

  assign accept   = bus.req_valid && req_ready_q;
  // The first command is built from the live request; later ones from the latched copy.
  assign src_addr = (state_q == StIdle) ? bus.req_addr : addr_q;
  assign src_op   = (state_q == StIdle) ? bus.req_op : op_q;
  assign lat      = (op_q == OpWrite) ? TCwl : TCl;

  dram_bank_table u_bank_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .lkp_idx  (addr_bank(bus.req_addr)),
    .lkp_open (lkp_open),
    .lkp_row  (lkp_row),
    .upd_en   (upd_en),
    .upd_idx  (addr_bank(src_addr)),
    .upd_open (upd_open),
    .upd_row  (upd_row)
  );

  // Next-state, delay counting and command/response formatting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    op_d        = op_q;
    addr_d      = addr_q;
    cmd_valid_d = 1'b0;
    cmd_type_d  = CmdNop;
    cmd_bg_d    = '0;
    cmd_ba_d    = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    rsp_valid_d = 1'b0;
    rsp_op_d    = '0;
    rsp_addr_d  = '0;
    upd_en      = 1'b0;
    upd_open    = 1'b0;
    upd_row     = '0;
    issue_pre   = 1'b0;
    issue_act   = 1'b0;
    issue_cas   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          cnt_d   = 8'd1;
          burst_d = 1'b0;
          if (!lkp_open) begin
            issue_act = 1'b1;
            state_d   = StAct;
          end else if (lkp_row == addr_row(bus.req_addr)) begin
            issue_cas = 1'b1;
            state_d   = StCas;
          end else begin
            issue_pre = 1'b1;
            state_d   = StPre;
          end
        end
      end
      StPre: begin
        if (cnt_q == TRp) begin
          issue_act = 1'b1;
          state_d   = StAct;
          cnt_d     = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StAct: begin
        if (cnt_q == TRcd) begin
          issue_cas = 1'b1;
          state_d   = StCas;
          cnt_d     = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCas, StData: begin
        // Two 8-bit phases (CAS latency, then burst) keep the counter narrow.
        state_d = StData;
        if (!burst_q) begin
          if (cnt_q == lat) begin
            burst_d = 1'b1;
            cnt_d   = 8'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (cnt_q == TBurst) begin
          rsp_valid_d = 1'b1;
          rsp_op_d    = op_q;
          rsp_addr_d  = addr_q;
          state_d     = StIdle;
          cnt_d       = '0;
          burst_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue_pre || issue_act || issue_cas) begin
      cmd_valid_d = 1'b1;
      cmd_bg_d    = addr_bg(src_addr);
      cmd_ba_d    = addr_ba(src_addr);
      cmd_col_d   = addr_col(src_addr);
    end
    if (issue_pre) begin
      cmd_type_d = CmdPre;
      upd_en     = 1'b1;
    end
    if (issue_act) begin
      cmd_type_d = CmdAct;
      cmd_row_d  = addr_row(src_addr);
      upd_en     = 1'b1;
      upd_open   = 1'b1;
      upd_row    = addr_row(src_addr);
    end
    if (issue_cas) begin
      cmd_type_d = cas_cmd(src_op);
    end

    req_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      burst_q     <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CmdNop;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_type  = cmd_type_q;
  assign bus.cmd_bg    = cmd_bg_q;
  assign bus.cmd_ba    = cmd_ba_q;
  assign bus.cmd_row   = cmd_row_q;
  assign bus.cmd_col   = cmd_col_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Bench for dram_cmd_sched: a schedule-level model predicts every output cycle by cycle.
module tb_dram_cmd_sched;
  import dram_pkg::*;

  localparam int TRcd   = 24;
  localparam int TRp    = 24;
  localparam int TCl    = 24;
  localparam int TCwl   = 20;
  localparam int TBurst = 4;

  typedef struct packed {
    logic        v;
    logic [2:0]  t;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [14:0] row;
    logic [7:0]  col;
  } cmd_t;

  typedef struct packed {
    logic        v;
    logic [1:0]  op;
    logic [32:0] addr;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  t;
    logic [14:0] row;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  dram_cmd_sched_if bus ();

  dram_cmd_sched #(
    .T_RCD   (TRcd),
    .T_RP    (TRp),
    .T_CL    (TCl),
    .T_CWL   (TCwl),
    .T_BURST (TBurst)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: expected command/response keyed by cycle, plus the open-page table.
  cmd_t        exp_cmd [int];
  rsp_t        exp_rsp [int];
  logic        m_open [16];
  logic [14:0] m_row [16];
  int          ready_from = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;

  obs_t        obs_cmds [$];
  int          obs_rsp_n = 0;
  int          obs_rsp_cyc = -1;
  logic [1:0]  obs_rsp_op = '0;

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Works out the whole command timeline of one accepted request from the page state.
  task automatic model_accept(input int a, input logic [1:0] op, input logic [32:0] addr);
    int          idx;
    int          t;
    int          r;
    logic [14:0] row;
    cmd_t        c;
    row   = addr[32:18];
    idx   = int'({addr[7:6], addr[9:8]});
    c.v   = 1'b1;
    c.bg  = addr[7:6];
    c.ba  = addr[9:8];
    c.col = addr[17:10];
    c.row = '0;
    t = a + 1;
    if (!(m_open[idx] && m_row[idx] == row)) begin
      if (m_open[idx]) begin
        c.t = CmdPre;
        exp_cmd[t] = c;
        t += TRp;
      end
      c.t   = CmdAct;
      c.row = row;
      exp_cmd[t] = c;
      t += TRcd;
      c.row = '0;
    end
    c.t = (op == 2'd1) ? CmdWr : CmdRd;
    exp_cmd[t] = c;
    r = t + ((op == 2'd1) ? TCwl : TCl) + TBurst;
    exp_rsp[r] = {1'b1, op, addr};
    m_open[idx] = 1'b1;
    m_row[idx]  = row;
    busy_lo    = a + 1;
    busy_hi    = r - 1;
    ready_from = r;
  endtask

  task automatic model_reset();
    exp_cmd.delete();
    exp_rsp.delete();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
    end
    busy_lo    = 1;
    busy_hi    = 0;
    ready_from = 32'h7fff_ffff;
  endtask

  task automatic check_cycle();
    cmd_t       ec;
    cmd_t       ac;
    rsp_t       er;
    rsp_t       ar;
    logic [1:0] ectl;
    logic [1:0] actl;
    ec   = '0;
    er   = '0;
    ectl = '0;
    if (rst_n) begin
      if (exp_cmd.exists(cyc)) ec = exp_cmd[cyc];
      if (exp_rsp.exists(cyc)) er = exp_rsp[cyc];
      ectl[1] = (cyc >= ready_from);
      ectl[0] = (cyc >= busy_lo) && (cyc <= busy_hi);
    end
    ac   = {bus.cmd_valid, bus.cmd_type, bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col};
    ar   = {bus.rsp_valid, bus.rsp_op, bus.rsp_addr};
    actl = {bus.req_ready, bus.busy};
    checks++;
    if (ac !== ec) begin
      errors++;
      $display("FAIL cmd cyc %0d got %h want %h", cyc, ac, ec);
    end
    checks++;
    if (ar !== er) begin
      errors++;
      $display("FAIL rsp cyc %0d got %h want %h", cyc, ar, er);
    end
    checks++;
    if (actl !== ectl) begin
      errors++;
      $display("FAIL ready_busy cyc %0d got %b want %b", cyc, actl, ectl);
    end
    if (bus.cmd_valid === 1'b1) obs_cmds.push_back('{cyc, bus.cmd_type, bus.cmd_row});
    if (bus.rsp_valid === 1'b1) begin
      obs_rsp_n++;
      obs_rsp_cyc = cyc;
      obs_rsp_op  = bus.rsp_op;
    end
  endtask

  // Compare process: one sample 1 ns after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      check_cycle();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc %0d got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] rand_addr();
    logic [32:0] x;
    x[5:0]   = 6'($urandom);
    x[7:6]   = 2'($urandom);
    x[9:8]   = 2'($urandom_range(0, 1));
    x[17:10] = 8'($urandom);
    x[32:18] = 15'($urandom_range(0, 3));
    return x;
  endfunction

  function automatic obs_t obs_get(input int i);
    obs_t o;
    o.cyc = -1000;
    o.t   = 3'h7;
    o.row = '1;
    if (i < obs_cmds.size()) o = obs_cmds[i];
    return o;
  endfunction

  task automatic clear_obs();
    obs_cmds.delete();
    obs_rsp_n   = 0;
    obs_rsp_cyc = -1000;
    obs_rsp_op  = '0;
  endtask

  task automatic chk_cmd(input string name, input int i, input int a, input logic [2:0] t,
                         input int off);
    obs_t o;
    o = obs_get(i);
    expect_int({name, "_type"}, int'(o.t), int'(t));
    expect_int({name, "_cyc"}, o.cyc - a, off);
  endtask

  // Called on a falling edge; returns on the falling edge of the cycle after release.
  task automatic do_reset(input int hold);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    ready_from = cyc + 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < ready_from && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc < ready_from) expect_int("idle_timeout", cyc, ready_from);
  endtask

  task automatic send(input logic [1:0] op, input logic [32:0] addr, output int a);
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    a = cyc;
    model_accept(a, op, addr);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_addr  = rand_addr();
  endtask

  initial begin
    int          a;
    obs_t        o;
    logic [1:0]  rop;
    logic [32:0] raddr;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    expect_int("rst_ready", int'(bus.req_ready), 0);
    expect_int("rst_busy", int'(bus.busy), 0);
    expect_int("rst_cmd_valid", int'(bus.cmd_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_from = cyc + 1;
    @(negedge clk);
    expect_int("rel_ready", int'(bus.req_ready), 1);

    // Read to an empty bank.
    clear_obs();
    send(2'd0, 33'h0_0000_0040, a);
    wait_idle();
    expect_int("empty_ncmd", obs_cmds.size(), 2);
    chk_cmd("empty_act", 0, a, CmdAct, 1);
    o = obs_get(0);
    expect_int("empty_act_row", int'(o.row), 0);
    chk_cmd("empty_rd", 1, a, CmdRd, 25);
    expect_int("empty_rsp", obs_rsp_cyc - a, 53);

    // Page hit on the same address.
    clear_obs();
    send(2'd0, 33'h0_0000_0040, a);
    wait_idle();
    expect_int("hit_ncmd", obs_cmds.size(), 1);
    chk_cmd("hit_rd", 0, a, CmdRd, 1);
    expect_int("hit_rsp", obs_rsp_cyc - a, 29);

    // Page miss: same bank, row 1.
    clear_obs();
    send(2'd0, 33'h0_0004_0040, a);
    wait_idle();
    expect_int("miss_ncmd", obs_cmds.size(), 3);
    chk_cmd("miss_pre", 0, a, CmdPre, 1);
    chk_cmd("miss_act", 1, a, CmdAct, 25);
    o = obs_get(1);
    expect_int("miss_act_row", int'(o.row), 1);
    chk_cmd("miss_rd", 2, a, CmdRd, 49);
    expect_int("miss_rsp", obs_rsp_cyc - a, 77);

    // Write hit to the now-open row 1.
    clear_obs();
    send(2'd1, 33'h0_0004_0040, a);
    wait_idle();
    expect_int("wr_ncmd", obs_cmds.size(), 1);
    chk_cmd("wr_wr", 0, a, CmdWr, 1);
    expect_int("wr_rsp", obs_rsp_cyc - a, 25);
    expect_int("wr_rsp_op", int'(obs_rsp_op), 1);

    // Bank independence: BG0 BA0 row 5, then BG3 BA3 row 5, then BG0 BA0 again.
    clear_obs();
    send(2'd2, 33'h0_0014_0000, a);
    wait_idle();
    chk_cmd("ind_first_act", 0, a, CmdAct, 1);
    clear_obs();
    send(2'd0, 33'h0_0014_03C0, a);
    wait_idle();
    expect_int("ind_ncmd", obs_cmds.size(), 2);
    chk_cmd("ind_act", 0, a, CmdAct, 1);
    clear_obs();
    send(2'd3, 33'h0_0014_0000, a);
    wait_idle();
    chk_cmd("ind_still_open", 0, a, CmdRd, 1);

    // Reset during the ACT-to-CAS wait.
    clear_obs();
    send(2'd0, 33'h0_001C_0180, a);
    repeat (9) @(negedge clk);
    do_reset(3);
    repeat (60) @(negedge clk);
    expect_int("rst_mid_ncmd", obs_cmds.size(), 1);
    chk_cmd("rst_mid_act", 0, a, CmdAct, 1);
    expect_int("rst_mid_rsp", obs_rsp_n, 0);
    clear_obs();
    send(2'd0, 33'h0_001C_0180, a);
    wait_idle();
    expect_int("rst_reopen_ncmd", obs_cmds.size(), 2);
    chk_cmd("rst_reopen_act", 0, a, CmdAct, 1);

    // Random traffic with junk on the request bus while busy and occasional resets.
    for (int k = 0; k < 8000; k++) begin
      if (cyc >= ready_from) begin
        if ($urandom_range(0, 299) == 0) begin
          do_reset($urandom_range(1, 3));
        end else if ($urandom_range(0, 2) == 0) begin
          rop   = 2'($urandom);
          raddr = rand_addr();
          bus.req_valid = 1'b1;
          bus.req_op    = rop;
          bus.req_addr  = raddr;
          model_accept(cyc, rop, raddr);
        end else begin
          bus.req_valid = 1'b0;
        end
      end else begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset($urandom_range(1, 3));
        end else begin
          bus.req_valid = 1'($urandom_range(0, 1));
          bus.req_op    = 2'($urandom);
          bus.req_addr  = rand_addr();
        end
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_cmd_sched.md
DRAM_CMD_SCHED -- requirements
Module: dram_cmd_sched

Interface
REQ-001 Parameter T_RCD, default 24, ACT-to-CAS delay in clocks.
REQ-002 Parameter T_RP, default 24, PRE-to-ACT delay in clocks.
REQ-003 Parameter T_CL, default 24, RD-to-data delay in clocks.
REQ-004 Parameter T_CWL, default 20, WR-to-data delay in clocks.
REQ-005 Parameter T_BURST, default 4, data burst length in clocks.
REQ-006 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-007 clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-008 req_valid  in  1  request present; req_ready  out  1  scheduler can accept.
REQ-009 req_op  in  2  0=data read, 1=data write, 2=instruction fetch (treated as read), 3=reserved (treated as read).
REQ-010 req_addr  in  33  byte address: BG=[7:6], BA=[9:8], row=[32:18], col=[17:10].
REQ-011 cmd_valid  out  1  one-cycle command strobe; cmd_type  out  3  NOP/ACT/PRE/RD/WR.
REQ-012 cmd_bg  out  2; cmd_ba  out  2; cmd_row  out  15; cmd_col  out  8 -- command fields.
REQ-013 rsp_valid  out  1  one-cycle completion pulse; rsp_op  out  2; rsp_addr  out  33 -- echo of the completed request.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 Handshake: transfer on a rising edge with req_valid && req_ready; req_ready = 1 only in IDLE; one request in flight.
REQ-016 Bank table: 16 entries indexed {BG,BA}, each open bit + 15-bit open row.
REQ-017 Classification at accept: hit = open && row match; empty = !open; miss = open && row differs.
REQ-018 FSM states IDLE, PRE, ACT, CAS, DATA; IDLE->CAS (hit), IDLE->ACT (empty), IDLE->PRE (miss); PRE->ACT after T_RP; ACT->CAS after T_RCD; CAS->DATA next cycle; DATA->IDLE after T_CL+T_BURST (read) or T_CWL+T_BURST (write).
REQ-019 First command issued the cycle after accept (cycle a+1); each later command issued exactly the programmed delay after the previous one.
REQ-020 PRE clears the entry's open bit; ACT sets it and loads the row; RD/WR leave it unchanged (open-page policy).
REQ-021 CAS issues WR for op 1, RD otherwise; cmd_col = req_addr[17:10]; cmd_row = row for ACT, 0 for PRE/RD/WR.
REQ-022 All outputs registered; cmd_valid = 0 and cmd_type = NOP on every non-issue cycle.
REQ-023 rsp_valid pulses on the cycle the DATA delay expires; the FSM returns to IDLE on that edge, so req_ready = 1 in the same cycle.
REQ-024 Delay counters 8 bits wide; parameter values must be 1..255; a value of 0 is a configuration error.
REQ-025 req_addr/req_op changes while req_ready = 0 are ignored; the request is latched at accept.

Reset
REQ-026 On rst_n low, immediately: state IDLE, all bank entries closed with row 0, counters 0, all outputs 0 except req_ready = 1 after release.
REQ-027 Reset mid-operation abandons the request with no rsp_valid; no command is issued during reset.

Structure
REQ-028 Package dram_pkg holds the cmd_type and op enums, address field bit positions, and timing defaults.
REQ-029 Sub-module dram_bank_table (16 x {open, row}, lookup + update ports) holds the bank table; the FSM and counters stay in dram_cmd_sched.

Verification (default parameters, a = accept cycle)
REQ-030 Read to empty bank: reset, then read addr 0x0_0000_0040 -> ACT BG1 BA0 row 0 at a+1, RD at a+25, rsp_valid at a+53.
REQ-031 Page hit: repeat the same read -> RD at a+1, no ACT/PRE, rsp_valid at a+29.
REQ-032 Page miss: read 0x0_0004_0040 after REQ-030 -> PRE at a+1, ACT row 1 at a+25, RD at a+49, rsp_valid at a+77.
REQ-033 Write hit: op 1 to an open row -> WR at a+1, rsp_valid at a+25, rsp_op = 1.
REQ-034 Bank independence: open BG0 BA0 row 5, then access BG3 BA3 row 5 -> ACT without PRE; the BG0 BA0 entry is still open.
REQ-035 Reset mid-ACT wait: assert rst_n low at a+10 -> no RD and no rsp_valid; after release the same address is classified empty.
